// File: rtl/tmr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tmr_pkg
// Description : Shared widths, reset constants and the prescaler terminal
//               count decode used by both ends of the prescaler interface.
// Revision    : 1.0 - initial release
// ============================================================================
package tmr_pkg;

  localparam int CNT_W  = 64;
  localparam int HALF_W = 32;
  localparam int PRE_W  = 8;

  localparam logic [CNT_W-1:0] CMP_RST = {CNT_W{1'b1}};

  // Terminal count of the prescaler for a given select. Selects of 8 and
  // above saturate at the full 8-bit range so both ends agree on the wrap.
  function automatic logic [PRE_W-1:0] tmr_lim(input logic [3:0] div_val);
    if (div_val >= 4'd8) begin
      tmr_lim = {PRE_W{1'b1}};
    end else begin
      tmr_lim = (PRE_W'(1) << div_val[2:0]) - PRE_W'(1);
    end
  endfunction

endpackage : tmr_pkg
`default_nettype wire

// File: rtl/tmr_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tmr_tick_gen
// Description : Derives the count-enable tick from the prescaler count and
//               detects the falling edge of timer_en.
// Ports       : clk, rst_n       - clock, async active-low reset
//               timer_en        - timer enable
//               div_en, div_val - prescaler enable / select
//               stop            - debug halt, suppresses the tick
//               i               - prescaler internal count
//               tick            - count-enable for this cycle
//               fall_edge_timer - timer_en 1->0 pulse
// Revision    : 1.0 - initial release
// ============================================================================
module tmr_tick_gen
  import tmr_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             timer_en,
  input  logic             div_en,
  input  logic [3:0]       div_val,
  input  logic             stop,
  input  logic [PRE_W-1:0] i,
  output logic             tick,
  output logic             fall_edge_timer
);

  logic             r_timer_en_q;
  logic [PRE_W-1:0] w_lim;
  logic             w_pre_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer_en_q <= 1'b0;
    end else begin
      r_timer_en_q <= timer_en;
    end
  end

  always_comb begin
    w_lim     = tmr_lim(div_val);
    // Without the prescaler every clock is a count event.
    w_pre_hit = div_en ? (i == w_lim) : 1'b1;
  end

  assign tick            = timer_en & ~stop & w_pre_hit;
  assign fall_edge_timer = r_timer_en_q & ~timer_en;

endmodule : tmr_tick_gen
`default_nettype wire

// File: rtl/tmr_cnt_cmp.sv
`default_nettype none
// ============================================================================
// Module      : tmr_cnt_cmp
// Description : 64-bit timer counter, compare register and sticky interrupt
//               status; consumer end of the prescaler interface.
// Ports       : clk, rst_n              - clock, async active-low reset
//               timer_en, div_en,        - control inputs
//               div_val, stop, i
//               wdata, wr_DR0/1          - counter word loads
//               wr_CMP0/1                - compare word loads
//               int_en, int_clr          - interrupt enable / W1C strobe
//               cnt, cmp                 - current counter / compare
//               int_st, tim_int          - sticky status / interrupt line
//               fall_edge_timer          - timer_en 1->0 pulse
//               halt_ack                 - debug halt acknowledge
// Revision    : 1.0 - initial release
// ============================================================================
module tmr_cnt_cmp
  import tmr_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              timer_en,
  input  logic              div_en,
  input  logic [3:0]        div_val,
  input  logic              stop,
  input  logic [PRE_W-1:0]  i,
  input  logic [HALF_W-1:0] wdata,
  input  logic              wr_DR0,
  input  logic              wr_DR1,
  input  logic              wr_CMP0,
  input  logic              wr_CMP1,
  input  logic              int_en,
  input  logic              int_clr,
  output logic [CNT_W-1:0]  cnt,
  output logic [CNT_W-1:0]  cmp,
  output logic              int_st,
  output logic              tim_int,
  output logic              fall_edge_timer,
  output logic              halt_ack
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_cmp;
  logic             r_int_st;
  logic             r_halt_ack;
  logic             w_tick;
  logic             w_fall_edge;

  tmr_tick_gen u_tick_gen (
    .clk             (clk),
    .rst_n           (rst_n),
    .timer_en        (timer_en),
    .div_en          (div_en),
    .div_val         (div_val),
    .stop            (stop),
    .i               (i),
    .tick            (w_tick),
    .fall_edge_timer (w_fall_edge)
  );

  // Software loads beat the disable clear, which beats counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (wr_DR0 || wr_DR1) begin
      if (wr_DR0) r_cnt[HALF_W-1:0]     <= wdata;
      if (wr_DR1) r_cnt[CNT_W-1:HALF_W] <= wdata;
    end else if (w_fall_edge) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= r_cnt + C_CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmp <= CMP_RST;
    end else begin
      if (wr_CMP0) r_cmp[HALF_W-1:0]     <= wdata;
      if (wr_CMP1) r_cmp[CNT_W-1:HALF_W] <= wdata;
    end
  end

  // Match is sampled every clock regardless of enable/halt; a match in the
  // same cycle as a clear keeps the status set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int_st <= 1'b0;
    end else if (r_cnt == r_cmp) begin
      r_int_st <= 1'b1;
    end else if (int_clr) begin
      r_int_st <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halt_ack <= 1'b0;
    end else begin
      r_halt_ack <= stop & timer_en;
    end
  end

  assign cnt             = r_cnt;
  assign cmp             = r_cmp;
  assign int_st          = r_int_st;
  assign tim_int         = r_int_st & int_en;
  assign fall_edge_timer = w_fall_edge;
  assign halt_ack        = r_halt_ack;

endmodule : tmr_cnt_cmp
`default_nettype wire

// File: tb/tb_tmr_cnt_cmp.sv
`default_nettype none
// ============================================================================
// Module      : tb_tmr_cnt_cmp
// Description : Self-checking bench for tmr_cnt_cmp: directed scenarios plus
//               randomized traffic against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tmr_cnt_cmp;

  logic        clk;
  logic        rst_n;
  logic        timer_en;
  logic        div_en;
  logic [3:0]  div_val;
  logic        stop;
  logic [7:0]  i;
  logic [31:0] wdata;
  logic        wr_DR0, wr_DR1, wr_CMP0, wr_CMP1;
  logic        int_en, int_clr;
  logic [63:0] cnt, cmp;
  logic        int_st, tim_int, fall_edge_timer, halt_ack;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [63:0] m_cnt, m_cmp;
  bit          m_int_st, m_te_q, m_halt;

  tmr_cnt_cmp dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .timer_en        (timer_en),
    .div_en          (div_en),
    .div_val         (div_val),
    .stop            (stop),
    .i               (i),
    .wdata           (wdata),
    .wr_DR0          (wr_DR0),
    .wr_DR1          (wr_DR1),
    .wr_CMP0         (wr_CMP0),
    .wr_CMP1         (wr_CMP1),
    .int_en          (int_en),
    .int_clr         (int_clr),
    .cnt             (cnt),
    .cmp             (cmp),
    .int_st          (int_st),
    .tim_int         (tim_int),
    .fall_edge_timer (fall_edge_timer),
    .halt_ack        (halt_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int lim_of(input int dv);
    return (dv >= 8) ? 255 : (2 ** dv) - 1;
  endfunction

  task automatic m_reset();
    m_cnt = 64'd0; m_cmp = '1; m_int_st = 0; m_te_q = 0; m_halt = 0;
  endtask

  task automatic clr_strobes();
    wr_DR0 = 0; wr_DR1 = 0; wr_CMP0 = 0; wr_CMP1 = 0; int_clr = 0;
  endtask

  // One clock: check combinational outputs, advance model, check registers.
  task automatic cyc();
    bit          fe, tk;
    logic [63:0] n_cnt, n_cmp;
    bit          n_int;
    #1;
    fe = m_te_q && !timer_en;
    tk = timer_en && !stop && (!div_en || (int'(i) == lim_of(int'(div_val))));
    check("fall_edge", {63'd0, fall_edge_timer}, {63'd0, fe});
    check("tim_int", {63'd0, tim_int}, {63'd0, m_int_st && int_en});
    n_cnt = m_cnt;
    if (wr_DR0 || wr_DR1) begin
      if (wr_DR0) n_cnt[31:0]  = wdata;
      if (wr_DR1) n_cnt[63:32] = wdata;
    end else if (fe) begin
      n_cnt = 64'd0;
    end else if (tk) begin
      n_cnt = m_cnt + 64'd1;
    end
    n_cmp = m_cmp;
    if (wr_CMP0) n_cmp[31:0]  = wdata;
    if (wr_CMP1) n_cmp[63:32] = wdata;
    n_int = (m_cnt == m_cmp) ? 1'b1 : (int_clr ? 1'b0 : m_int_st);
    @(posedge clk);
    m_halt   = stop && timer_en;
    m_te_q   = timer_en;
    m_cnt    = n_cnt;
    m_cmp    = n_cmp;
    m_int_st = n_int;
    #1;
    check("cnt", cnt, m_cnt);
    check("cmp", cmp, m_cmp);
    check("int_st", {63'd0, int_st}, {63'd0, m_int_st});
    check("halt_ack", {63'd0, halt_ack}, {63'd0, m_halt});
  endtask

  task automatic write_cnt(input logic [31:0] d, input bit lo, input bit hi);
    wdata = d; wr_DR0 = lo; wr_DR1 = hi;
    cyc();
    clr_strobes();
  endtask

  task automatic write_cmp(input logic [31:0] d, input bit lo, input bit hi);
    wdata = d; wr_CMP0 = lo; wr_CMP1 = hi;
    cyc();
    clr_strobes();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cnt"}, cnt, 64'd0);
    check({tag, "_cmp"}, cmp, 64'hFFFF_FFFF_FFFF_FFFF);
    check({tag, "_int_st"}, {63'd0, int_st}, 64'd0);
    check({tag, "_tim_int"}, {63'd0, tim_int}, 64'd0);
    check({tag, "_fe"}, {63'd0, fall_edge_timer}, 64'd0);
    check({tag, "_halt"}, {63'd0, halt_ack}, 64'd0);
  endtask

  initial begin
    logic [63:0] base;
    int          ictr;
    rst_n = 0; timer_en = 0; div_en = 0; div_val = 0; stop = 0; i = 0;
    wdata = 0; int_en = 0;
    clr_strobes();
    m_reset();
    repeat (3) @(posedge clk);
    #2;
    timer_en = 1; // timer_en_q is held in reset, so no edge here
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1;

    // Free-running count, no prescaler
    repeat (10) cyc();
    check("cnt10", cnt, 64'd10);
    check("cmp_rst", cmp, 64'hFFFF_FFFF_FFFF_FFFF);
    check("int_st_idle", {63'd0, int_st}, 64'd0);

    // Prescaler select 2: tick when i==3
    div_en = 1; div_val = 2;
    base = m_cnt;
    for (int k = 0; k < 16; k++) begin
      i = 8'(k % 4);
      cyc();
    end
    check("div2_total", cnt, base + 64'd4);
    div_en = 0; i = 0;

    // Wrap from all-ones with cmp = 0
    int_en = 1;
    write_cmp(32'd0, 1, 1);
    write_cnt(32'hFFFF_FFFF, 1, 0);
    write_cnt(32'hFFFF_FFFF, 0, 1);
    check("cnt_ones", cnt, 64'hFFFF_FFFF_FFFF_FFFF);
    stop = 0; cyc();
    check("cnt_wrap", cnt, 64'd0);
    stop = 1; cyc();
    check("wrap_int_st", {63'd0, int_st}, 64'd1);
    #1;
    check("wrap_tim_int", {63'd0, tim_int}, 64'd1);
    stop = 0; cyc(); cyc();
    int_clr = 1; cyc(); int_clr = 0;
    check("clr_after_wrap", {63'd0, int_st}, 64'd0);

    // Set beats clear while cnt==5
    write_cmp(32'd5, 1, 0);
    write_cnt(32'd0, 1, 1);
    write_cnt(32'd4, 1, 0);
    cyc();
    check("cnt5", cnt, 64'd5);
    stop = 1; int_clr = 1;
    repeat (4) cyc();
    check("set_wins", {63'd0, int_st}, 64'd1);
    stop = 0; int_clr = 0;
    cyc();
    check("cnt6", cnt, 64'd6);
    int_clr = 1; cyc(); int_clr = 0;
    check("clr_pulse", {63'd0, int_st}, 64'd0);

    // Debug halt
    write_cnt(32'h1234, 1, 0);
    stop = 1;
    repeat (5) cyc();
    check("halt_frozen", cnt, 64'h1234);
    check("halt_ack_on", {63'd0, halt_ack}, 64'd1);
    stop = 0;
    cyc();
    check("halt_ack_off", {63'd0, halt_ack}, 64'd0);
    check("halt_resume", cnt, 64'h1235);

    // Disable edge clears; load beats clear
    write_cnt(32'd77, 1, 0);
    stop = 1; cyc();
    timer_en = 0; #1;
    check("fe_pulse", {63'd0, fall_edge_timer}, 64'd1);
    cyc();
    check("fe_clear", cnt, 64'd0);
    stop = 0; timer_en = 1;
    repeat (3) cyc();
    timer_en = 0;
    write_cnt(32'd9, 1, 0);
    check("write_beats_clear", cnt, 64'd9);
    timer_en = 1;

    // Randomized traffic
    ictr = 0;
    for (int k = 0; k < 600; k++) begin
      timer_en = ($urandom_range(0, 15) != 0);
      stop     = ($urandom_range(0, 7) == 0);
      div_en   = $urandom_range(0, 1);
      div_val  = 4'($urandom_range(0, 15));
      ictr++;
      i        = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(ictr & lim_of(int'(div_val)));
      int_en   = $urandom_range(0, 1);
      int_clr  = ($urandom_range(0, 3) == 0);
      wdata    = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : 32'($urandom);
      if ($urandom_range(0, 1) == 1 && wdata > 32'd40) wdata = 32'hFFFF_FFFF;
      wr_DR0   = ($urandom_range(0, 15) == 0);
      wr_DR1   = ($urandom_range(0, 15) == 0);
      wr_CMP0  = ($urandom_range(0, 15) == 0);
      wr_CMP1  = ($urandom_range(0, 15) == 0);
      cyc();
      clr_strobes();
    end

    // Asynchronous reset mid-count
    timer_en = 1; stop = 0; div_en = 0; int_en = 1;
    write_cnt(32'd0, 1, 1);
    write_cmp(32'd3, 1, 1);
    repeat (6) cyc();
    #3;
    rst_n = 0;
    #1;
    m_reset();
    check_reset_vals("async_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_tmr_cnt_cmp
`default_nettype wire
